// File: rtl/rc5_cipher_param.sv
// RC5 encrypt/decrypt engine, W-bit words, ROUNDS rounds, with a writable round-key table.
// Blocks enter and leave through valid/ready handshakes; key writes are accepted only while idle.
module rc5_cipher_param #(
   parameter int W      = 16,
   parameter int ROUNDS = 12
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*W-1:0]   in_data,
   input  logic             in_decrypt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   out_data,
   input  logic             key_we,
   input  logic [7:0]       key_addr,
   input  logic [W-1:0]     key_wdata,
   output logic             key_wr_err
);

   // state  | meaning
   // IDLE   | waiting for a block; key writes allowed
   // PRE    | key whitening with S[0], S[1] (first step encrypt, last step decrypt)
   // HALF_A | A half-round using S[2i]
   // HALF_B | B half-round using S[2i+1]
   // DONE   | result presented until out_ready

   localparam int NK = 2*ROUNDS + 2;
   localparam int KW = $clog2(NK);
   localparam int LW = $clog2(W);

   typedef enum logic [2:0] {IDLE, PRE, HALF_A, HALF_B, DONE} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   a_q, b_q, a_nxt, b_nxt;
   logic [7:0]     i_q, i_nxt;
   logic           dec_q, dec_nxt;
   logic [W-1:0]   key_tbl [NK];
   logic [KW-1:0]  idx_a, idx_b;
   logic           key_ok;

   function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] s);
      logic [2*W-1:0] t;
      t = {x, x} << s;
      return t[2*W-1:W];
   endfunction

   function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LW-1:0] s);
      logic [2*W-1:0] t;
      t = {x, x} >> s;
      return t[W-1:0];
   endfunction

   assign idx_a     = KW'({i_q, 1'b0});
   assign idx_b     = KW'({i_q, 1'b1});
   assign key_ok    = ({1'b0, key_addr} <= 9'(NK-1));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      a_nxt     = a_q;
      b_nxt     = b_q;
      i_nxt     = i_q;
      dec_nxt   = dec_q;
      case (state)
         IDLE: begin
            if (in_valid) begin
               a_nxt     = in_data[2*W-1:W];
               b_nxt     = in_data[W-1:0];
               dec_nxt   = in_decrypt;
               i_nxt     = in_decrypt ? 8'(ROUNDS) : 8'd1;
               state_nxt = in_decrypt ? HALF_B : PRE;
            end
         end
         PRE: begin
            if (!dec_q) begin
               a_nxt     = a_q + key_tbl[0];
               b_nxt     = b_q + key_tbl[1];
               state_nxt = HALF_A;
            end else begin
               a_nxt     = a_q - key_tbl[0];
               b_nxt     = b_q - key_tbl[1];
               state_nxt = DONE;
            end
         end
         HALF_A: begin
            if (!dec_q) begin
               a_nxt     = rotl(a_q ^ b_q, b_q[LW-1:0]) + key_tbl[idx_a];
               state_nxt = HALF_B;
            end else begin
               a_nxt = rotr(a_q - key_tbl[idx_a], b_q[LW-1:0]) ^ b_q;
               if (i_q == 8'd1) begin
                  state_nxt = PRE;
               end else begin
                  i_nxt     = i_q - 8'd1;
                  state_nxt = HALF_B;
               end
            end
         end
         HALF_B: begin
            if (!dec_q) begin
               b_nxt = rotl(b_q ^ a_q, a_q[LW-1:0]) + key_tbl[idx_b];
               if (i_q == 8'(ROUNDS)) begin
                  state_nxt = DONE;
               end else begin
                  i_nxt     = i_q + 8'd1;
                  state_nxt = HALF_A;
               end
            end else begin
               b_nxt     = rotr(b_q - key_tbl[idx_b], a_q[LW-1:0]) ^ a_q;
               state_nxt = HALF_A;
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         a_q        <= '0;
         b_q        <= '0;
         i_q        <= '0;
         dec_q      <= 1'b0;
         out_data   <= '0;
         key_wr_err <= 1'b0;
         for (int k = 0; k < NK; k++) key_tbl[k] <= '0;
      end else begin
         a_q        <= a_nxt;
         b_q        <= b_nxt;
         i_q        <= i_nxt;
         dec_q      <= dec_nxt;
         key_wr_err <= key_we && !(state == IDLE && key_ok);
         // result is captured once, on entry to DONE, so it stays stable through stalls
         if (state != DONE && state_nxt == DONE) out_data <= {a_nxt, b_nxt};
         if (key_we && state == IDLE && key_ok) key_tbl[KW'(key_addr)] <= key_wdata;
      end
   end

endmodule

// File: tb/tb_rc5_cipher_param.sv
// Bench for rc5_cipher_param: W=8/ROUNDS=1 instance for known answers and corner cases,
// W=16/ROUNDS=12 instance for random encrypt/decrypt round trips and throughput.
module tb_rc5_cipher_param;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic        rst8, iv8, ir8, dec8, ov8, or8, kwe8, ke8;
   logic [15:0] id8, od8;
   logic [7:0]  ka8, kd8;

   logic        rst16, iv16, ir16, dec16, ov16, or16, kwe16, ke16;
   logic [31:0] id16, od16;
   logic [7:0]  ka16;
   logic [15:0] kd16;

   rc5_cipher_param #(.W(8), .ROUNDS(1)) u8 (
      .clock(clock), .reset(rst8),
      .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_decrypt(dec8),
      .out_valid(ov8), .out_ready(or8), .out_data(od8),
      .key_we(kwe8), .key_addr(ka8), .key_wdata(kd8), .key_wr_err(ke8));

   rc5_cipher_param #(.W(16), .ROUNDS(12)) u16 (
      .clock(clock), .reset(rst16),
      .in_valid(iv16), .in_ready(ir16), .in_data(id16), .in_decrypt(dec16),
      .out_valid(ov16), .out_ready(or16), .out_data(od16),
      .key_we(kwe16), .key_addr(ka16), .key_wdata(kd16), .key_wr_err(ke16));

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] mkeys [26];

   typedef struct {
      string       name;
      logic        dec;
      logic [15:0] din;
      logic [15:0] dout;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, want);
   endtask

   function automatic logic [31:0] mrotl(input logic [31:0] x, input int n, input int w);
      logic [31:0] mask;
      mask = (32'h1 << w) - 32'h1;
      if (n == 0) return x;
      return ((x << n) | (x >> (w - n))) & mask;
   endfunction

   function automatic logic [31:0] model_enc(input int w, input int r, input logic [31:0] blk);
      logic [31:0] mask, a, b;
      mask = (32'h1 << w) - 32'h1;
      a = (blk >> w) & mask;
      b = blk & mask;
      a = (a + mkeys[0]) & mask;
      b = (b + mkeys[1]) & mask;
      for (int i = 1; i <= r; i++) begin
         a = (mrotl(a ^ b, int'(b & 32'(w - 1)), w) + mkeys[2*i]) & mask;
         b = (mrotl(b ^ a, int'(a & 32'(w - 1)), w) + mkeys[2*i+1]) & mask;
      end
      return (a << w) | b;
   endfunction

   task automatic wkey8(input logic [7:0] addr, input logic [7:0] data);
      kwe8 = 1'b1; ka8 = addr; kd8 = data;
      @(posedge clock); #1;
      kwe8 = 1'b0;
   endtask

   task automatic wkey16(input logic [7:0] addr, input logic [15:0] data);
      kwe16 = 1'b1; ka16 = addr; kd16 = data;
      @(posedge clock); #1;
      kwe16 = 1'b0;
   endtask

   task automatic start8(input logic dec, input logic [15:0] din);
      int n = 0;
      while (!ir8 && n < 200) begin @(posedge clock); #1; n++; end
      check("in_ready8 before accept", ir8, 1);
      iv8 = 1'b1; id8 = din; dec8 = dec;
      @(posedge clock); #1;
      iv8 = 1'b0;
   endtask

   task automatic wait8(output logic [15:0] dout, output int edges);
      edges = 0;
      while (!ov8 && edges < 100) begin @(posedge clock); #1; edges++; end
      check("out_valid8 seen", ov8, 1);
      dout = od8;
   endtask

   task automatic ack8();
      or8 = 1'b1;
      @(posedge clock); #1;
      or8 = 1'b0;
   endtask

   task automatic run16(input logic dec, input logic [31:0] din, output logic [31:0] dout,
                        output int acc);
      int n = 0;
      while (!ir16 && n < 200) begin @(posedge clock); #1; n++; end
      iv16 = 1'b1; id16 = din; dec16 = dec;
      @(posedge clock); #1;
      acc  = cyc;
      iv16 = 1'b0;
      n = 0;
      while (!ov16 && n < 100) begin @(posedge clock); #1; n++; end
      check("out_valid16 seen", ov16, 1);
      dout = od16;
      @(posedge clock); #1;
   endtask

   initial begin
      logic [15:0] d8;
      logic [31:0] pt, ct, rt, kv;
      int          edges, acc, prev_acc;

      vecs[0] = '{"enc 0000", 1'b0, 16'h0000, 16'h2F9E};
      vecs[1] = '{"dec 2F9E", 1'b1, 16'h2F9E, 16'h0000};
      vecs[2] = '{"enc 0102", 1'b0, 16'h0102, 16'hCBCD};
      vecs[3] = '{"dec CBCD", 1'b1, 16'hCBCD, 16'h0102};
      vecs[4] = '{"enc FFFF", 1'b0, 16'hFFFF, 16'h0703};
      vecs[5] = '{"dec 0703", 1'b1, 16'h0703, 16'hFFFF};

      rst8 = 1'b0; iv8 = 1'b0; dec8 = 1'b0; or8 = 1'b0; kwe8 = 1'b0;
      id8 = '0; ka8 = '0; kd8 = '0;
      rst16 = 1'b0; iv16 = 1'b0; dec16 = 1'b0; or16 = 1'b0; kwe16 = 1'b0;
      id16 = '0; ka16 = '0; kd16 = '0;
      repeat (2) @(posedge clock);
      #1;
      check("reset8 outputs", {ir8, ov8, ke8, od8}, {1'b1, 1'b0, 1'b0, 16'h0000});
      check("reset16 outputs", {ir16, ov16, ke16, od16}, {1'b1, 1'b0, 1'b0, 32'h0});
      rst8 = 1'b1; rst16 = 1'b1;

      wkey8(8'd0, 8'h20); wkey8(8'd1, 8'h10); wkey8(8'd2, 8'hFF); wkey8(8'd3, 8'hFF);
      check("key_wr_err on legal write", ke8, 0);

      for (int v = 0; v < 6; v++) begin
         start8(vecs[v].dec, vecs[v].din);
         wait8(d8, edges);
         check({vecs[v].name, " data"}, d8, vecs[v].dout);
         check({vecs[v].name, " edges incl accept"}, edges + 1, 4);
         ack8();
         check({vecs[v].name, " idle after ack"}, {ir8, ov8}, 2'b10);
      end

      // stall in DONE with out_ready low; stray in_valid pulses must be ignored
      start8(1'b0, 16'hFFFF);
      wait8(d8, edges);
      for (int s = 0; s < 10; s++) begin
         iv8 = 1'b1; id8 = 16'h1234; dec8 = 1'b1;
         @(posedge clock); #1;
         check("stall ov/ir/data", {ov8, ir8, od8}, {1'b1, 1'b0, 16'h0703});
      end
      iv8 = 1'b0;
      ack8();
      repeat (5) begin
         @(posedge clock); #1;
         check("no accept from stall pulses", {ir8, ov8}, 2'b10);
      end

      // key write while busy is rejected
      start8(1'b0, 16'h0000);
      @(posedge clock); #1;
      kwe8 = 1'b1; ka8 = 8'd2; kd8 = 8'h00;
      @(posedge clock); #1;
      kwe8 = 1'b0;
      check("key_wr_err busy write", ke8, 1);
      wait8(d8, edges);
      check("key_wr_err one cycle", ke8, 0);
      check("enc after busy write", d8, 16'h2F9E);
      ack8();

      // out-of-range address is rejected even in IDLE
      wkey8(8'd4, 8'h00);
      check("key_wr_err addr 4", ke8, 1);
      @(posedge clock); #1;
      check("key_wr_err clears", ke8, 0);
      start8(1'b0, 16'h0000);
      wait8(d8, edges);
      check("enc after rejected writes", d8, 16'h2F9E);
      ack8();

      // reset mid-encryption clears state, outputs and key table
      start8(1'b0, 16'h0102);
      @(posedge clock); #1;
      rst8 = 1'b0;
      @(posedge clock); #1;
      rst8 = 1'b1;
      check("mid-op reset outputs", {ir8, ov8, od8}, {1'b1, 1'b0, 16'h0000});
      for (int k = 0; k < 26; k++) mkeys[k] = '0;
      start8(1'b0, 16'h0000);
      wait8(d8, edges);
      check("zero-key enc 0000", d8, 16'(model_enc(8, 1, 32'h0000)));
      ack8();
      start8(1'b0, 16'h0102);
      wait8(d8, edges);
      check("zero-key enc 0102", d8, 16'(model_enc(8, 1, 32'h0102)));
      ack8();

      // key write and block accept in the same IDLE cycle
      kwe8 = 1'b1; ka8 = 8'd0; kd8 = 8'h20;
      iv8 = 1'b1; id8 = 16'h0000; dec8 = 1'b0;
      @(posedge clock); #1;
      kwe8 = 1'b0; iv8 = 1'b0;
      check("same-cycle write accepted", ke8, 0);
      mkeys[0] = 32'h20;
      wait8(d8, edges);
      check("same-cycle key used", d8, 16'(model_enc(8, 1, 32'h0000)));
      ack8();

      // W=16, ROUNDS=12: random keys, round trips, back-to-back throughput
      for (int k = 0; k < 26; k++) begin
         kv = $urandom & 32'hFFFF;
         mkeys[k] = kv;
         wkey16(8'(k), kv[15:0]);
      end
      or16 = 1'b1;
      prev_acc = -1;
      for (int blk = 0; blk < 1000; blk++) begin
         pt = $urandom;
         run16(1'b0, pt, ct, acc);
         check("enc16 vs model", ct, model_enc(16, 12, pt));
         if (prev_acc >= 0) check("accept spacing", acc - prev_acc, 27);
         prev_acc = acc;
         run16(1'b1, ct, rt, acc);
         check("round trip", rt, pt);
         check("accept spacing", acc - prev_acc, 27);
         prev_acc = acc;
      end
      or16 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
